// File: rtl/parity_frame_arbiter_if.sv
// Purpose : Bundles the two requester handshakes and the serial-line outputs
//           of parity_frame_arbiter.
// Modports: master - requester side (drives valid/word/parity_control,
//                    observes ready and the line outputs)
//           slave  - arbiter side (the design itself)
// Signals :
//   req0_valid / req1_valid                    requester has a word
//   req0_word / req1_word                      8-bit data word
//   req0_parity_control / req1_parity_control  0 = even, 1 = odd parity
//   req0_ready / req1_ready                    word accepted when valid also high
//   ser_out                                    serial line, idle high
//   ser_busy                                   frame in progress
//   frame_done                                 pulse on the final stop-bit clock
//   grant_id                                   owner of the current/last frame
interface parity_frame_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [7:0] req0_word;
    logic [7:0] req1_word;
    logic       req0_parity_control;
    logic       req1_parity_control;
    logic       req0_ready;
    logic       req1_ready;
    logic       ser_out;
    logic       ser_busy;
    logic       frame_done;
    logic       grant_id;

    modport master (
        output req0_valid, req1_valid, req0_word, req1_word,
               req0_parity_control, req1_parity_control,
        input  req0_ready, req1_ready, ser_out, ser_busy, frame_done, grant_id
    );

    modport slave (
        input  req0_valid, req1_valid, req0_word, req1_word,
               req0_parity_control, req1_parity_control,
        output req0_ready, req1_ready, ser_out, ser_busy, frame_done, grant_id
    );
endinterface

// File: rtl/parity_frame_arbiter.sv
// Purpose : Two-requester arbiter that serialises one accepted 8-bit word at a
//           time as start(0), data bits LSB first, parity, stop(1), each bit
//           held BIT_CYCLES clocks, optionally followed by GAP_CYCLES idle-high
//           clocks.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    parity_frame_arbiter_if.slave (handshakes + line outputs)
// Params  : BIT_CYCLES 1..255, GAP_CYCLES 0..255
// Macro   : PARITY_ARB_ROUND_ROBIN_EN - when defined, contention is resolved
//           round-robin (the requester other than the last accepted one wins);
//           when undefined, requester 0 always wins.
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | line high, ready offered to the selected requester
// S_START  | start bit (0)
// S_DATA   | data bits 0..7, LSB first
// S_PARITY | parity bit
// S_STOP   | stop bit (1); frame_done on its last clock
// S_GAP    | idle-high spacing before the next acceptance
module parity_frame_arbiter #(
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    parity_frame_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    // Down-counter reload values; GAP_LOAD is only used when GAP_CYCLES > 0.
    localparam logic [7:0] BIT_LOAD = 8'(BIT_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       grant_q, grant_d;

    logic       idle;
    logic       sel;
    logic       accept;
    logic       tc;
    logic       ser;

    assign idle = (state_q == S_IDLE);
    assign tc   = (cnt_q == 8'd0);

`ifdef PARITY_ARB_ROUND_ROBIN_EN
    // Holds the last accepted requester; resets to 1 so requester 0 wins first.
    logic last_q;

    assign sel = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= sel;
        end
    end
`else
    assign sel = ~bus.req0_valid & bus.req1_valid;
`endif

    assign bus.req0_ready = idle & ~sel;
    assign bus.req1_ready = idle &  sel;
    assign accept         = idle & (sel ? bus.req1_valid : bus.req0_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            grant_q   <= grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        grant_d   = grant_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    cnt_d   = BIT_LOAD;
                    grant_d = sel;
                    if (sel) begin
                        shift_d  = bus.req1_word;
                        parity_d = ^bus.req1_word ^ bus.req1_parity_control;
                    end else begin
                        shift_d  = bus.req0_word;
                        parity_d = ^bus.req0_word ^ bus.req0_parity_control;
                    end
                end
            end
            S_START: begin
                if (tc) begin
                    state_d   = S_DATA;
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (tc) begin
                    cnt_d = BIT_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PARITY: begin
                if (tc) begin
                    state_d = S_STOP;
                    cnt_d   = BIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STOP: begin
                if (tc) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (tc) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line is decoded from registered state only, so the async reset drives it
    // high immediately.
    always_comb begin
        ser = 1'b1;
        case (state_q)
            S_START:  ser = 1'b0;
            S_DATA:   ser = shift_q[0];
            S_PARITY: ser = parity_q;
            default:  ser = 1'b1;
        endcase
    end

    assign bus.ser_out    = ser;
    assign bus.ser_busy   = ~idle;
    assign bus.frame_done = (state_q == S_STOP) & tc;
    assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
module tb_parity_frame_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    parity_frame_arbiter_if ifa ();
    parity_frame_arbiter_if ifb ();

    parity_frame_arbiter #(.BIT_CYCLES(1), .GAP_CYCLES(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    parity_frame_arbiter #(.BIT_CYCLES(2), .GAP_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    // Stimulus, indexed [dut][requester]
    logic       vld [2][2];
    logic [7:0] wrd [2][2];
    logic       pcb [2][2];

    assign ifa.req0_valid          = vld[0][0];
    assign ifa.req1_valid          = vld[0][1];
    assign ifa.req0_word           = wrd[0][0];
    assign ifa.req1_word           = wrd[0][1];
    assign ifa.req0_parity_control = pcb[0][0];
    assign ifa.req1_parity_control = pcb[0][1];
    assign ifb.req0_valid          = vld[1][0];
    assign ifb.req1_valid          = vld[1][1];
    assign ifb.req0_word           = wrd[1][0];
    assign ifb.req1_word           = wrd[1][1];
    assign ifb.req0_parity_control = pcb[1][0];
    assign ifb.req1_parity_control = pcb[1][1];

    logic [1:0] rdy0, rdy1, sero, busy, done, gid;
    assign rdy0[0] = ifa.req0_ready;  assign rdy0[1] = ifb.req0_ready;
    assign rdy1[0] = ifa.req1_ready;  assign rdy1[1] = ifb.req1_ready;
    assign sero[0] = ifa.ser_out;     assign sero[1] = ifb.ser_out;
    assign busy[0] = ifa.ser_busy;    assign busy[1] = ifb.ser_busy;
    assign done[0] = ifa.frame_done;  assign done[1] = ifb.frame_done;
    assign gid[0]  = ifa.grant_id;    assign gid[1]  = ifb.grant_id;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is just "accepted at cycle k with word w and
    // parity p"; everything else is arithmetic on the offset from k.
    int         cyc = 0;
    int         acc_k [2];
    bit         has   [2];
    logic [7:0] mw    [2];
    logic       mp    [2];
    logic       mg    [2];
    logic       mlast [2];
    bit         acc_now [2][2];

    int   acc_q [$];
    logic glog  [$];
    int   r1_seen_a = 0;

    function automatic int bc_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int gc_of(int d);
        return (d == 0) ? 3 : 0;
    endfunction

    function automatic bit m_idle(int d);
        return !has[d] || ((cyc - acc_k[d]) > 11 * bc_of(d) + gc_of(d));
    endfunction

    // {ser_out, ser_busy, frame_done}
    function automatic logic [2:0] m_line(int d);
        int   off, slot;
        logic s;
        if (m_idle(d)) return 3'b100;
        off  = cyc - acc_k[d];
        slot = (off - 1) / bc_of(d);
        if (slot == 0)      s = 1'b0;
        else if (slot <= 8) s = mw[d][slot - 1];
        else if (slot == 9) s = mp[d];
        else                s = 1'b1;
        return {s, 1'b1, (off == 11 * bc_of(d))};
    endfunction

    function automatic int m_pick(int d);
        if (!m_idle(d)) return -1;
        if (vld[d][0] && vld[d][1]) begin
`ifdef PARITY_ARB_ROUND_ROBIN_EN
            return mlast[d] ? 0 : 1;
`else
            return 0;
`endif
        end
        if (vld[d][0]) return 0;
        if (vld[d][1]) return 1;
        return -1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            has[d]   = 1'b0;
            mg[d]    = 1'b0;
            mlast[d] = 1'b1;
            acc_now[d][0] = 1'b0;
            acc_now[d][1] = 1'b0;
        end
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic step();
        int         p [2];
        bit         oacc;
        logic [2:0] ln;
        #2;
        oacc = (rdy0[0] & vld[0][0]) | (rdy1[0] & vld[0][1]);
        if (rdy1[0]) r1_seen_a++;
        for (int d = 0; d < 2; d++) begin
            p[d] = m_pick(d);
            if (p[d] >= 0) begin
                check($sformatf("ready0_dut%0d", d), rdy0[d], p[d] == 0);
                check($sformatf("ready1_dut%0d", d), rdy1[d], p[d] == 1);
            end else if (!m_idle(d)) begin
                check($sformatf("ready_busy_dut%0d", d), {rdy0[d], rdy1[d]}, 0);
            end else begin
                check($sformatf("ready_onehot_dut%0d", d), rdy0[d] & rdy1[d], 0);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc_now[d][0] = 1'b0;
            acc_now[d][1] = 1'b0;
            if (p[d] >= 0) begin
                has[d]   = 1'b1;
                acc_k[d] = cyc;
                mw[d]    = wrd[d][p[d]];
                mp[d]    = (^wrd[d][p[d]]) ^ pcb[d][p[d]];
                mg[d]    = p[d][0];
                mlast[d] = p[d][0];
                acc_now[d][p[d]] = 1'b1;
            end
        end
        cyc++;
        #1;
        if (oacc) begin
            acc_q.push_back(cyc);
            glog.push_back(gid[0]);
        end
        for (int d = 0; d < 2; d++) begin
            ln = m_line(d);
            check($sformatf("ser_out_dut%0d", d),    sero[d], ln[2]);
            check($sformatf("ser_busy_dut%0d", d),   busy[d], ln[1]);
            check($sformatf("frame_done_dut%0d", d), done[d], ln[0]);
            check($sformatf("grant_id_dut%0d", d),   gid[d],  mg[d]);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (busy == 2'b00) return;
            step();
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic drive_random();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                if (acc_now[d][r] || !vld[d][r]) begin
                    vld[d][r] = 1'($urandom_range(0, 1));
                    wrd[d][r] = 8'($urandom);
                    pcb[d][r] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 7) == 0) begin
                    vld[d][r] = 1'b0;
                end
            end
        end
    endtask

    logic [10:0] sa, sb1, sb2, exp_b;
    int          da, db;
    logic        exp_g [4];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                vld[d][r] = 1'b0;
                wrd[d][r] = 8'h00;
                pcb[d][r] = 1'b0;
            end
        end
        model_reset();

        // Reset values
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ser_out",    sero, 2'b11);
        check("rst_ser_busy",   busy, 2'b00);
        check("rst_frame_done", done, 2'b00);
        check("rst_grant_id",   gid,  2'b00);
        rst_n = 1'b1;

        // Contention: both requesters valid continuously
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                vld[d][r] = 1'b1;
                wrd[d][r] = 8'($urandom);
                pcb[d][r] = 1'($urandom_range(0, 1));
            end
        end
        glog.delete();
        acc_q.delete();
        r1_seen_a = 0;
        for (int i = 0; i < 200 && glog.size() < 4; i++) step();
        check("contention_grant_count", glog.size(), 4);
`ifdef PARITY_ARB_ROUND_ROBIN_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
        check("fixed_req1_never_ready", r1_seen_a, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            if (glog.size() > i) check($sformatf("contention_grant%0d", i), glog[i], exp_g[i]);
        end
        for (int d = 0; d < 2; d++) begin
            vld[d][0] = 1'b0;
            vld[d][1] = 1'b0;
        end
        wait_idle();

        // dut_a: req0 0x00 even; dut_b: req1 0xA5 odd
        vld[0][0] = 1'b1; wrd[0][0] = 8'h00; pcb[0][0] = 1'b0;
        vld[1][1] = 1'b1; wrd[1][1] = 8'hA5; pcb[1][1] = 1'b1;
        sa = '0; sb1 = '0; sb2 = '0; da = -1; db = -1;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (t == 1) begin
                vld[0][0] = 1'b0;
                vld[1][1] = 1'b0;
            end
            if (t <= 11) sa[t - 1] = sero[0];
            if (t <= 22) begin
                if (t % 2 == 1) sb1[(t - 1) / 2] = sero[1];
                else            sb2[(t - 2) / 2] = sero[1];
            end
            if (done[0] && da < 0) da = t;
            if (done[1] && db < 0) db = t;
            if (t == 5) begin
                check("frame_a_grant", gid[0], 1'b0);
                check("frame_b_grant", gid[1], 1'b1);
            end
        end
        check("frame_a_bits", sa, 11'b10000000000);
        check("frame_a_done_offset", da, 11);
        exp_b = 11'b11101001010;
        check("frame_b_bits_first_clock",  sb1, exp_b);
        check("frame_b_bits_second_clock", sb2, exp_b);
        check("frame_b_done_offset", db, 22);
        wait_idle();

        // Back-to-back req0 on dut_a with a 3-cycle gap
        acc_q.delete();
        vld[0][0] = 1'b1; wrd[0][0] = 8'($urandom); pcb[0][0] = 1'b1;
        for (int i = 0; i < 100 && acc_q.size() < 3; i++) begin
            step();
            if (acc_now[0][0]) wrd[0][0] = 8'($urandom);
        end
        check("gap_accept_count", acc_q.size(), 3);
        for (int i = 1; i < 3; i++) begin
            if (acc_q.size() > i) check($sformatf("gap_spacing%0d", i), acc_q[i] - acc_q[i - 1], 15);
        end
        vld[0][0] = 1'b0;
        wait_idle();

        // Reset in the middle of data bit 4, then a clean frame
        vld[0][0] = 1'b1; wrd[0][0] = 8'hEF; pcb[0][0] = 1'b0;
        step();
        vld[0][0] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_data_bit4", sero[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ser_out", sero[0], 1'b1);
        check("async_reset_busy", busy[0], 1'b0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_no_frame_done", done, 2'b00);
            check("reset_ser_high", sero, 2'b11);
        end
        rst_n = 1'b1;
        vld[0][0] = 1'b1; wrd[0][0] = 8'h7F; pcb[0][0] = 1'b0;
        da = -1;
        for (int t = 1; t <= 16; t++) begin
            step();
            if (t == 1) begin
                check("post_reset_first_edge_accept", busy[0], 1'b1);
                vld[0][0] = 1'b0;
            end
            if (t == 10) check("post_reset_parity_bit", sero[0], 1'b1);
            if (done[0] && da < 0) da = t;
        end
        check("post_reset_done_offset", da, 11);
        wait_idle();

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            step();
            drive_random();
        end
        for (int d = 0; d < 2; d++) begin
            vld[d][0] = 1'b0;
            vld[d][1] = 1'b0;
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
